// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS core front end.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pcnext_calc.sv
// Next-PC selection for the fetch stage: jump target, branch target or fall-through.
module pcnext_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] pcplus4,
    input  logic [XLEN-1:0] instr,
    input  logic            pcsrc,
    input  logic            jump,
    output logic [XLEN-1:0] pcnext
);

    logic [XLEN-1:0] branchoffset;
    logic            unused_instr_hi;

    assign unused_instr_hi = ^instr[31:26];

    // Jump wins over branch when the controller asserts both.
    always_comb begin
        branchoffset = {{14{instr[15]}}, instr[15:0], 2'b00};
        pcnext       = pcplus4;
        if (jump) begin
            pcnext = {pcplus4[31:28], instr[25:0], 2'b00};
        end else if (pcsrc) begin
            pcnext = pcplus4 + branchoffset;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/resp handshake,
// and holds each instruction until the downstream retires it.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instr,
    output logic               instr_valid,
    output logic [OP_W-1:0]    op,
    output logic [FUNCT_W-1:0] funct,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pcplus4,
    input  logic               pcsrc,
    input  logic               jump,
    input  logic               retire,
    output logic [XLEN-1:0]    retired_count
);

    fetch_state_t    state;
    fetch_state_t    statenext;
    logic [XLEN-1:0] pcnext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= statenext;
        end
    end

    // Each state only listens to the handshake input that belongs to it.
    always_comb begin
        statenext = state;
        case (state)
            FETCH:   if (imem_ready)  statenext = WAIT;
            WAIT:    if (imem_rvalid) statenext = HOLD;
            HOLD:    if (retire)      statenext = FETCH;
            default: statenext = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= RESET_PC;
            instr         <= '0;
            retired_count <= '0;
        end else begin
            if (state == WAIT && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (state == HOLD && retire) begin
                pc            <= pcnext;
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    pcnext_calc u_pcnext_calc (
        .pcplus4 (pcplus4),
        .instr   (instr),
        .pcsrc   (pcsrc),
        .jump    (jump),
        .pcnext  (pcnext)
    );

    // Request is suppressed while reset is held so the memory never sees a stray fetch.
    assign imem_req    = reset_n && (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign pcplus4     = pc + 32'd4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; a second instance with a high RESET_PC exercises the jump region bits.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pcsrc;
    logic        jump;
    logic        retire;

    logic        a_req,   b_req;
    logic [31:0] a_addr,  b_addr;
    logic [31:0] a_instr, b_instr;
    logic        a_valid, b_valid;
    logic [5:0]  a_op,    b_op;
    logic [5:0]  a_funct, b_funct;
    logic [31:0] a_pc,    b_pc;
    logic [31:0] a_pcp4,  b_pcp4;
    logic [31:0] a_count, b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(a_instr), .instr_valid(a_valid), .op(a_op), .funct(a_funct),
        .pc(a_pc), .pcplus4(a_pcp4), .pcsrc(pcsrc), .jump(jump),
        .retire(retire), .retired_count(a_count)
    );

    ifetch_unit #(.RESET_PC(32'h1000_0000)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(b_instr), .instr_valid(b_valid), .op(b_op), .funct(b_funct),
        .pc(b_pc), .pcplus4(b_pcp4), .pcsrc(pcsrc), .jump(jump),
        .retire(retire), .retired_count(b_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                                 input logic ps, input logic jp, input logic rt);
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rd;
        pcsrc       = ps;
        jump        = jp;
        retire      = rt;
    endtask

    // Zero-wait fetch of one instruction, retired immediately; entered and left just after a negedge in FETCH.
    task automatic fetchOne(input string tag, input logic [31:0] data,
                            input logic [31:0] exp_a, input logic [31:0] exp_b,
                            input logic ps, input logic jp);
        logic [31:0] opexp;
        logic [31:0] functexp;
        opexp    = {26'd0, data[31:26]};
        functexp = {26'd0, data[5:0]};
        checkOutput({tag, " req"},      {31'd0, a_req}, 32'd1);
        checkOutput({tag, " addr_a"},   a_addr, exp_a);
        checkOutput({tag, " addr_b"},   b_addr, exp_b);
        checkOutput({tag, " pcplus4"},  a_pcp4, exp_a + 32'd4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({tag, " wait req"}, {31'd0, a_req}, 32'd0);
        checkOutput({tag, " wait vld"}, {31'd0, a_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({tag, " hold vld"}, {31'd0, a_valid}, 32'd1);
        checkOutput({tag, " instr"},    a_instr, data);
        checkOutput({tag, " op"},       {26'd0, a_op}, opexp);
        checkOutput({tag, " funct"},    {26'd0, a_funct}, functexp);
        applyStimulus(1'b0, 1'b0, 32'h0, ps, jp, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst req_a",   {31'd0, a_req}, 32'd0);
        checkOutput("rst req_b",   {31'd0, b_req}, 32'd0);
        checkOutput("rst pc_a",    a_pc, 32'h0000_0000);
        checkOutput("rst pc_b",    b_pc, 32'h1000_0000);
        checkOutput("rst instr",   a_instr, 32'h0);
        checkOutput("rst valid",   {31'd0, a_valid}, 32'd0);
        checkOutput("rst count",   a_count, 32'd0);

        reset_n = 1'b1;
        #1;
        checkOutput("release req", {31'd0, a_req}, 32'd1);

        // Back-to-back adds at three cycles each.
        fetchOne("add0", 32'h0000_0020, 32'h0000_0000, 32'h1000_0000, 1'b0, 1'b0);
        fetchOne("add1", 32'h0000_0020, 32'h0000_0004, 32'h1000_0004, 1'b0, 1'b0);
        fetchOne("add2", 32'h0000_0020, 32'h0000_0008, 32'h1000_0008, 1'b0, 1'b0);
        checkOutput("count3 a", a_count, 32'd3);
        checkOutput("count3 b", b_count, 32'd3);
        checkOutput("addr after 3", a_addr, 32'h0000_000C);
        fetchOne("add3", 32'h0000_0020, 32'h0000_000C, 32'h1000_000C, 1'b0, 1'b0);

        // Backpressure with stray rvalid/retire that must be ignored in FETCH.
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp req",   {31'd0, a_req}, 32'd1);
            checkOutput("bp addr",  a_addr, 32'h0000_0010);
            checkOutput("bp valid", {31'd0, a_valid}, 32'd0);
            checkOutput("bp instr", a_instr, 32'h0000_0020);
            checkOutput("bp count", a_count, 32'd4);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        fetchOne("after bp", 32'h0000_0020, 32'h0000_0010, 32'h1000_0010, 1'b0, 1'b0);
        checkOutput("addr after bp", a_addr, 32'h0000_0014);

        // Reset in the middle of a request, then a stale response in FETCH.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mid wait req", {31'd0, a_req}, 32'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst pc_a",  a_pc, 32'h0000_0000);
        checkOutput("midrst pc_b",  b_pc, 32'h1000_0000);
        checkOutput("midrst count", a_count, 32'd0);
        checkOutput("midrst instr", a_instr, 32'h0);
        checkOutput("midrst req",   {31'd0, a_req}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("stale valid", {31'd0, a_valid}, 32'd0);
        checkOutput("stale instr", a_instr, 32'h0);
        checkOutput("stale req",   {31'd0, a_req}, 32'd1);
        checkOutput("stale addr",  a_addr, 32'h0000_0000);
        checkOutput("stale count", a_count, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Jump beats branch, then branches back onto itself, forward, and down to the wrap point.
        fetchOne("jump",   32'h0800_0040, 32'h0000_0000, 32'h1000_0000, 1'b1, 1'b1);
        fetchOne("br m1",  32'h1000_FFFF, 32'h0000_0100, 32'h1000_0100, 1'b1, 1'b0);
        fetchOne("br p3",  32'h1000_0003, 32'h0000_0100, 32'h1000_0100, 1'b1, 1'b0);
        fetchOne("br neg", 32'h1000_FFBA, 32'h0000_0110, 32'h1000_0110, 1'b1, 1'b0);
        checkOutput("wrap pcplus4_a", a_pcp4, 32'h0000_0000);
        checkOutput("wrap pcplus4_b", b_pcp4, 32'h1000_0000);
        fetchOne("wrap", 32'h0000_0020, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b0, 1'b0);
        checkOutput("wrap addr_a", a_addr, 32'h0000_0000);
        checkOutput("wrap addr_b", b_addr, 32'h1000_0000);
        checkOutput("final count", a_count, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
